// File: rtl/moving_cars_pkg.sv
// Shared road/car geometry, colours and game state for the car layers.
// Imported by the moving-cars generator, player car and compositor.
package moving_cars_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int CAR_W      = 32;
    localparam int CAR_H      = 48;
    localparam int NUM_CARS   = 3;
    localparam int LANE0_X    = 200;
    localparam int LANE_PITCH = 80;
    localparam int SPEED      = 2;
    localparam int STAGGER    = 176;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CRASH
    } game_state_t;

    // Car colours; the compositor keys on BLACK/WHITE,
    // so none of these may be either.
    function automatic logic [11:0] car_rgb(input int idx);
        logic [11:0] c;
        case (idx)
            0:       c = 12'hF00;
            1:       c = 12'h0F0;
            default: c = 12'h00F;
        endcase
        return c;
    endfunction

    function automatic logic [9:0] lane_x(input logic [1:0] lane);
        return 10'(LANE0_X) + 10'(LANE_PITCH) * 10'(lane);
    endfunction

endpackage

// File: rtl/moving_cars_gen_hit_box.sv
// car_hit_box: combinational overlap test of a car box against a query box.
// Ports: car_x/car_yb (car left edge, bottom edge), qx/qy/qw/qh (query box),
// hit (boxes overlap). A 1x1 query box gives a point-in-box test.
module car_hit_box
    import moving_cars_pkg::*;
(
    input  logic [9:0] car_x,
    input  logic [9:0] car_yb,
    input  logic [9:0] qx,
    input  logic [9:0] qy,
    input  logic [6:0] qw,
    input  logic [6:0] qh,
    output logic       hit
);

    // Signed 12-bit so yb-CAR_H may go negative and sums never wrap.
    logic signed [11:0] cx;
    logic signed [11:0] cyb;
    logic signed [11:0] cyt;
    logic signed [11:0] x0;
    logic signed [11:0] y0;
    logic signed [11:0] w;
    logic signed [11:0] h;

    assign cx  = signed'({2'b00, car_x});
    assign cyb = signed'({2'b00, car_yb});
    assign cyt = cyb - 12'(CAR_H);
    assign x0  = signed'({2'b00, qx});
    assign y0  = signed'({2'b00, qy});
    assign w   = signed'({5'b00000, qw});
    assign h   = signed'({5'b00000, qh});

    assign hit = (x0 < cx + 12'(CAR_W)) && (cx < x0 + w)
              && (y0 < cyb) && (cyt < y0 + h);

endmodule

// File: rtl/moving_cars_gen.sv
// moving_cars_gen: obstacle cars scrolling down the lanes, rendered per pixel.
// Ports: clk, reset_n, pix_row/pix_col/video_on (dtg), frame_tick, run,
// player_x/player_y (player box), moving_cars_out (RGB444, 1 clk latency),
// collision (state is CRASH), score (cars passed, saturating).
module moving_cars_gen
    import moving_cars_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pix_row,
    input  logic [9:0]  pix_col,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        run,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    output logic [11:0] moving_cars_out,
    output logic        collision,
    output logic [7:0]  score
);

    localparam logic [10:0] YB_WRAP = 11'(SCREEN_H + CAR_H);

    game_state_t         state;
    logic [7:0]          lfsr;
    logic [9:0]          yb      [NUM_CARS];
    logic [1:0]          lane    [NUM_CARS];
    logic [9:0]          car_x   [NUM_CARS];
    logic [10:0]         yb_next [NUM_CARS];
    logic [NUM_CARS-1:0] pix_hit;
    logic [NUM_CARS-1:0] crash_hit;
    logic [1:0]          new_lane;
    logic [7:0]          score_next;
    logic [11:0]         pix_rgb;

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
        assign car_x[g]   = lane_x(lane[g]);
        assign yb_next[g] = {1'b0, yb[g]} + 11'(SPEED);

        car_hit_box u_pix (
            .car_x  (car_x[g]),
            .car_yb (yb[g]),
            .qx     (pix_col),
            .qy     (pix_row),
            .qw     (7'd1),
            .qh     (7'd1),
            .hit    (pix_hit[g])
        );

        car_hit_box u_crash (
            .car_x  (car_x[g]),
            .car_yb (yb[g]),
            .qx     (player_x),
            .qy     (player_y),
            .qw     (7'(CAR_W)),
            .qh     (7'(CAR_H)),
            .hit    (crash_hit[g])
        );
    end

    // Lane 3 does not exist; fold it onto the middle lane.
    assign new_lane = (lfsr[1:0] == 2'd3) ? 2'd1 : lfsr[1:0];

    // Each car wrapping this tick scores once, saturating at 255.
    always_comb begin
        score_next = score;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (yb_next[i] >= YB_WRAP && score_next != 8'hFF)
                score_next = score_next + 8'd1;
        end
    end

    // Lowest index wins, so scan from the top down.
    always_comb begin
        pix_rgb = BLACK;
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            if (pix_hit[i])
                pix_rgb = car_rgb(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lfsr <= 8'hA5;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            collision <= 1'b0;
            score     <= 8'd0;
            for (int i = 0; i < NUM_CARS; i++) begin
                yb[i]   <= 10'(i * STAGGER);
                lane[i] <= 2'(i);
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (run)
                        state <= RUN;
                end
                RUN: begin
                    if (!run) begin
                        state <= IDLE;
                        score <= 8'd0;
                        for (int i = 0; i < NUM_CARS; i++) begin
                            yb[i]   <= 10'(i * STAGGER);
                            lane[i] <= 2'(i);
                        end
                    end else if (frame_tick) begin
                        // A hit on the old positions freezes the cars.
                        if (|crash_hit) begin
                            state     <= CRASH;
                            collision <= 1'b1;
                        end else begin
                            score <= score_next;
                            for (int i = 0; i < NUM_CARS; i++) begin
                                if (yb_next[i] >= YB_WRAP) begin
                                    yb[i]   <= 10'd0;
                                    lane[i] <= new_lane;
                                end else begin
                                    yb[i] <= yb_next[i][9:0];
                                end
                            end
                        end
                    end
                end
                CRASH: begin
                    if (!run) begin
                        state     <= IDLE;
                        collision <= 1'b0;
                        score     <= 8'd0;
                        for (int i = 0; i < NUM_CARS; i++) begin
                            yb[i]   <= 10'(i * STAGGER);
                            lane[i] <= 2'(i);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    collision <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            moving_cars_out <= BLACK;
        else if (video_on && state != IDLE
                 && pix_row < 10'(SCREEN_H))
            moving_cars_out <= pix_rgb;
        else
            moving_cars_out <= BLACK;
    end

endmodule
